fpnew_issue_sequencer: RTL and testbench
========================================

# fpnew_issue_sequencer

Initiator-side companion to the FPNew blackbox wrapper. It accepts FPU requests from a client and issues them on the FPU input handshake, assigning a unique tag to each. It collects tagged results from the FPU output handshake, restores program order in a tag-indexed reorder buffer, and handles pipeline flush and drain. It sits between an issue stage or accelerator front-end and the FPU.

## Interface
- FLEN, 64: operand/result width.
- TAG_WIDTH, 2: tag width; DEPTH = 2**TAG_WIDTH outstanding ops max.
- CMD_WIDTH, 16: opaque packed command (op, op_mod, rnd_mode, fmts, vectorial), forwarded unchanged.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; **asynchronous, active-high** (one clock domain).
- req_valid_i / req_ready_o  in/out  1  client request handshake.
- req_operands_i  in  3*FLEN  operands {c,b,a}.
- req_cmd_i  in  CMD_WIDTH  command bundle.
- resp_valid_o / resp_ready_i  out/in  1  client response handshake.
- resp_result_o  out  FLEN  result.
- resp_status_o  out  5  {NV,DZ,OF,UF,NX}.
- resp_tag_o  out  TAG_WIDTH  tag of the returned op.
- flush_i  in  1  discard all in-flight work.
- busy_o  out  1  ops outstanding or draining.
- tag_err_o  out  1  one-cycle pulse on an unexpected FPU result tag.
- fpu_in_valid_o / fpu_in_ready_i  out/in  1  FPU input handshake.
- fpu_operands_o  out  3*FLEN, fpu_cmd_o  out  CMD_WIDTH, fpu_tag_o  out  TAG_WIDTH.
- fpu_flush_o  out  1  flush to FPU.
- fpu_out_valid_i / fpu_out_ready_o  in/out  1  FPU output handshake.
- fpu_result_i  in  FLEN, fpu_status_i  in  5, fpu_tag_i  in  TAG_WIDTH, fpu_busy_i  in  1.

## Operation
- Issue: can_issue = (state==RUN) && (count<DEPTH). Assignments: fpu_in_valid_o = req_valid_i & can_issue; req_ready_o = fpu_in_ready_i & can_issue. Operands and cmd pass through combinationally. fpu_tag_o = alloc_ptr. An issue is an FPU input handshake. It sets inflight[alloc_ptr] and increments alloc_ptr mod DEPTH.
- Result capture: fpu_out_ready_o = 1 in RUN and DRAIN. On an FPU output handshake in RUN with inflight[fpu_tag_i]=1, write rob[tag] = {result, status} and set done[tag]. If inflight[tag]=0, discard the result and pulse tag_err_o.
- Retire: resp_valid_o = done[retire_ptr]. On a response handshake, clear inflight and done at retire_ptr and increment retire_ptr.
- count = number of inflight bits. Simultaneous issue and retire leave count unchanged.
- State machine: RUN, then FLUSH, then DRAIN, then RUN.
  - RUN→FLUSH on flush_i.
  - FLUSH lasts 1 cycle: fpu_flush_o=1; clear inflight, done, alloc_ptr and retire_ptr.
  - DRAIN: discard all FPU results without pulsing tag_err_o. Exit to RUN when fpu_busy_i=0 && fpu_out_valid_i=0.
  - flush_i in FLUSH or DRAIN re-enters FLUSH.
- In FLUSH and DRAIN, can_issue=0 and resp_valid_o=0. flush_i wins over a same-cycle request or response: neither handshake completes.
- busy_o = (count!=0) || state!=RUN.
- Reset (async): state=RUN, pointers=0, inflight=done=0.
  - While rst_i=1: req_ready_o, fpu_in_valid_o, fpu_out_ready_o, resp_valid_o, fpu_flush_o, busy_o and tag_err_o are all 0.
  - Reset asserted mid-operation drops all state without flushing the FPU, because the FPU is reset by the same source.

## Timing
- Request→FPU: 0 cycles (combinational).
- FPU result→resp_valid_o: earliest the next cycle (ROB registered), only if the op is at the head.
- Full: with count=DEPTH, req_ready_o=0 until a retire. A retire in cycle N allows an issue in cycle N+1.
- Pointer wrap-around is modulo DEPTH. Tags are reused only after retire.
- resp_* is held stable while resp_valid_o=1 && resp_ready_i=0.
- Flush: fpu_flush_o high the cycle after flush_i. Minimum 2 cycles until RUN.

## Configuration
- FPNEW_ISSUE_REORDER_EN defined: in-order return through the ROB, as described above.
- FPNEW_ISSUE_REORDER_EN undefined:
  - ROB storage is removed.
  - Pass-through assignments: resp_valid_o = fpu_out_valid_i (RUN only); fpu_out_ready_o = resp_ready_i; resp_* = fpu_*_i.
  - On handshake, clear inflight[fpu_tag_i]. Results return out of order, identified by resp_tag_o.
  - Tag allocation takes the lowest free tag. count and flush behaviour are unchanged.

## Test plan
- Reset: assert rst_i with req_valid_i=1 → all outputs 0. Release, issue op → fpu_tag_o=0, then 1, 2, 3.
- Full: issue 4 ops, hold resp_ready_i=0 → req_ready_o=0 on the 5th. Retire one → 5th issues the next cycle with tag 0.
- Reorder (REORDER_EN): FPU returns tags 2,0,1 with results 0x3,0x1,0x2 → client sees tags 0,1,2 and results 0x1,0x2,0x3.
- No reorder: same stimulus → client sees tags 2,0,1 in arrival order.
- Flush: 3 in flight, flush_i pulse, FPU returns tag 1 during DRAIN and fpu_busy_i falls 2 cycles later → fpu_flush_o 1 cycle, no response, no tag_err_o, RUN resumes and next tag=0.
- Spurious tag: result with tag 3 when only tag 0 is in flight → tag_err_o pulses 1 cycle, ROB unchanged.

Source files
------------

// File: rtl/fpnew_issue_sequencer_if.sv
// Handshake bundle between fpnew_issue_sequencer, its client and the FPU.
// master: the sequencer's view. slave: the client/FPU environment's view.
interface fpnew_issue_sequencer_if #(
  parameter int unsigned FLEN      = 64,
  parameter int unsigned TAG_WIDTH = 2,
  parameter int unsigned CMD_WIDTH = 16
);
  // Client request
  logic                   req_valid_i;
  logic                   req_ready_o;
  logic [3*FLEN-1:0]      req_operands_i;
  logic [CMD_WIDTH-1:0]   req_cmd_i;
  // Client response
  logic                   resp_valid_o;
  logic                   resp_ready_i;
  logic [FLEN-1:0]        resp_result_o;
  logic [4:0]             resp_status_o;
  logic [TAG_WIDTH-1:0]   resp_tag_o;
  // Control / status
  logic                   flush_i;
  logic                   busy_o;
  logic                   tag_err_o;
  // FPU input side
  logic                   fpu_in_valid_o;
  logic                   fpu_in_ready_i;
  logic [3*FLEN-1:0]      fpu_operands_o;
  logic [CMD_WIDTH-1:0]   fpu_cmd_o;
  logic [TAG_WIDTH-1:0]   fpu_tag_o;
  logic                   fpu_flush_o;
  // FPU output side
  logic                   fpu_out_valid_i;
  logic                   fpu_out_ready_o;
  logic [FLEN-1:0]        fpu_result_i;
  logic [4:0]             fpu_status_i;
  logic [TAG_WIDTH-1:0]   fpu_tag_i;
  logic                   fpu_busy_i;

  modport master (
    input  req_valid_i, req_operands_i, req_cmd_i, resp_ready_i, flush_i,
           fpu_in_ready_i, fpu_out_valid_i, fpu_result_i, fpu_status_i, fpu_tag_i,
           fpu_busy_i,
    output req_ready_o, resp_valid_o, resp_result_o, resp_status_o, resp_tag_o,
           busy_o, tag_err_o, fpu_in_valid_o, fpu_operands_o, fpu_cmd_o, fpu_tag_o,
           fpu_flush_o, fpu_out_ready_o
  );

  modport slave (
    output req_valid_i, req_operands_i, req_cmd_i, resp_ready_i, flush_i,
           fpu_in_ready_i, fpu_out_valid_i, fpu_result_i, fpu_status_i, fpu_tag_i,
           fpu_busy_i,
    input  req_ready_o, resp_valid_o, resp_result_o, resp_status_o, resp_tag_o,
           busy_o, tag_err_o, fpu_in_valid_o, fpu_operands_o, fpu_cmd_o, fpu_tag_o,
           fpu_flush_o, fpu_out_ready_o
  );
endinterface

// File: rtl/fpnew_issue_sequencer.sv
// Issue sequencer in front of an FPNew FPU: tags requests, collects tagged results,
// handles flush/drain.
// Build option FPNEW_ISSUE_REORDER_EN: when defined, results are returned in program order
// through a tag-indexed reorder buffer; when undefined, results pass straight through in
// arrival order and freed tags are reallocated lowest-first.
module fpnew_issue_sequencer #(
  parameter int unsigned FLEN      = 64,
  parameter int unsigned TAG_WIDTH = 2,
  parameter int unsigned CMD_WIDTH = 16
) (
  input logic                     clk_i,
  input logic                     rst_i,
  fpnew_issue_sequencer_if.master bus
);

  localparam int unsigned Depth = 2 ** TAG_WIDTH;

  typedef logic [TAG_WIDTH-1:0] tag_t;
  typedef enum logic [1:0] {StRun, StFlush, StDrain} state_e;

  state_e           state_q, state_d;
  logic [Depth-1:0] inflight_q, inflight_d;
  logic             tag_err_q, tag_err_d;

  logic run_st, full, can_issue, issue, fpu_out_hs, tag_known;
  logic retire, spurious;
  tag_t alloc_tag, retire_tag;

  assign run_st    = (state_q == StRun);
  assign full      = &inflight_q;
  // Reset and a same-cycle flush both block new issues
  assign can_issue = run_st & ~full & ~bus.flush_i & ~rst_i;

  assign bus.fpu_in_valid_o = bus.req_valid_i & can_issue;
  assign bus.req_ready_o    = bus.fpu_in_ready_i & can_issue;
  assign bus.fpu_operands_o = bus.req_operands_i;
  assign bus.fpu_cmd_o      = bus.req_cmd_i[CMD_WIDTH-1:0];
  assign bus.fpu_tag_o      = alloc_tag;
  assign bus.fpu_flush_o    = (state_q == StFlush) & ~rst_i;
  assign bus.busy_o         = ~rst_i & ((|inflight_q) | ~run_st);
  assign bus.tag_err_o      = tag_err_q;

  assign issue      = bus.fpu_in_valid_o & bus.fpu_in_ready_i;
  assign fpu_out_hs = bus.fpu_out_valid_i & bus.fpu_out_ready_o;
  assign tag_known  = inflight_q[bus.fpu_tag_i];
  // Only results arriving in RUN can be unexpected; DRAIN discards silently
  assign spurious   = fpu_out_hs & run_st & ~tag_known;

`ifdef FPNEW_ISSUE_REORDER_EN

  tag_t             alloc_ptr_q, alloc_ptr_d;
  tag_t             retire_ptr_q, retire_ptr_d;
  logic [Depth-1:0] done_q, done_d;
  logic [FLEN+4:0]  rob_q [Depth];
  logic             capture;

  assign alloc_tag  = alloc_ptr_q;
  assign retire_tag = retire_ptr_q;
  assign capture    = fpu_out_hs & run_st & tag_known;

  assign bus.fpu_out_ready_o = ~rst_i & (run_st | (state_q == StDrain));
  assign bus.resp_valid_o    = ~rst_i & run_st & ~bus.flush_i & done_q[retire_ptr_q];
  assign bus.resp_result_o   = rob_q[retire_ptr_q][FLEN+4:5];
  assign bus.resp_status_o   = rob_q[retire_ptr_q][4:0];
  assign bus.resp_tag_o      = retire_ptr_q;

  assign retire = bus.resp_valid_o & bus.resp_ready_i;

  // Pointer and completion bookkeeping; a flush rewinds everything to tag 0
  always_comb begin
    alloc_ptr_d  = alloc_ptr_q;
    retire_ptr_d = retire_ptr_q;
    done_d       = done_q;
    if (issue) alloc_ptr_d = alloc_ptr_q + 1'b1;
    if (capture) done_d[bus.fpu_tag_i] = 1'b1;
    if (retire) begin
      done_d[retire_ptr_q] = 1'b0;
      retire_ptr_d         = retire_ptr_q + 1'b1;
    end
    if (state_q == StFlush) begin
      alloc_ptr_d  = '0;
      retire_ptr_d = '0;
      done_d       = '0;
    end
  end

  // Reorder bookkeeping registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      alloc_ptr_q  <= '0;
      retire_ptr_q <= '0;
      done_q       <= '0;
    end else begin
      alloc_ptr_q  <= alloc_ptr_d;
      retire_ptr_q <= retire_ptr_d;
      done_q       <= done_d;
    end
  end

  // ROB payload; validity lives in done_q so no reset is needed
  always_ff @(posedge clk_i) begin
    if (capture) rob_q[bus.fpu_tag_i] <= {bus.fpu_result_i, bus.fpu_status_i};
  end

`else

  // Lowest free tag wins
  always_comb begin
    alloc_tag = '0;
    for (int i = Depth - 1; i >= 0; i--) begin
      if (!inflight_q[i]) alloc_tag = tag_t'(i);
    end
  end

  assign retire_tag = bus.fpu_tag_i;

  // Unknown tags are accepted regardless of the client so they can be dropped and flagged
  assign bus.fpu_out_ready_o = ~rst_i & ((state_q == StDrain) |
                               (run_st & ~bus.flush_i & (bus.resp_ready_i | ~tag_known)));
  assign bus.resp_valid_o    = ~rst_i & run_st & ~bus.flush_i & bus.fpu_out_valid_i & tag_known;
  assign bus.resp_result_o   = bus.fpu_result_i[FLEN-1:0];
  assign bus.resp_status_o   = bus.fpu_status_i;
  assign bus.resp_tag_o      = bus.fpu_tag_i;

  assign retire = bus.resp_valid_o & bus.resp_ready_i;

`endif

  // In-flight tracking shared by both return modes
  always_comb begin
    inflight_d = inflight_q;
    if (issue) inflight_d[alloc_tag] = 1'b1;
    if (retire) inflight_d[retire_tag] = 1'b0;
    if (state_q == StFlush) inflight_d = '0;
  end

  assign tag_err_d = spurious;

  // RUN -> FLUSH -> DRAIN -> RUN; any flush request restarts at FLUSH
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:   if (bus.flush_i) state_d = StFlush;
      StFlush: state_d = bus.flush_i ? StFlush : StDrain;
      StDrain: begin
        if (bus.flush_i) state_d = StFlush;
        else if (!bus.fpu_busy_i && !bus.fpu_out_valid_i) state_d = StRun;
      end
      default: state_d = StRun;
    endcase
  end

  // Shared state registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StRun;
      inflight_q <= '0;
      tag_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      tag_err_q  <= tag_err_d;
    end
  end

endmodule

// File: tb/tb_fpnew_issue_sequencer.sv
// Directed bench for fpnew_issue_sequencer; expectations follow the build option
// FPNEW_ISSUE_REORDER_EN (in-order ROB return vs. arrival-order pass-through).
module tb_fpnew_issue_sequencer;

  localparam int unsigned FLEN      = 64;
  localparam int unsigned TAG_WIDTH = 2;
  localparam int unsigned CMD_WIDTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  fpnew_issue_sequencer_if #(
    .FLEN     (FLEN),
    .TAG_WIDTH(TAG_WIDTH),
    .CMD_WIDTH(CMD_WIDTH)
  ) bus ();

  fpnew_issue_sequencer #(
    .FLEN     (FLEN),
    .TAG_WIDTH(TAG_WIDTH),
    .CMD_WIDTH(CMD_WIDTH)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_req(input int i);
    bus.req_operands_i = {64'hC0 + 64'(i), 64'hB0 + 64'(i), 64'hA0 + 64'(i)};
    bus.req_cmd_i      = 16'h1230 + 16'(i);
  endtask

  // Return-sequence tables (FPU tags 2,0,1 with results 3,1,2)
  logic [1:0]  rt_fv [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [1:0]  rt_ft [6] = '{2'd2, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0};
  logic [63:0] rt_fr [6] = '{64'h3, 64'h1, 64'h2, 64'h0, 64'h0, 64'h0};
`ifdef FPNEW_ISSUE_REORDER_EN
  logic        ex_v   [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [1:0]  ex_tag [6] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd0};
  logic [63:0] ex_res [6] = '{64'h0, 64'h0, 64'h1, 64'h2, 64'h3, 64'h0};
  logic [1:0]  fl_tag [3] = '{2'd3, 2'd0, 2'd1};
`else
  logic        ex_v   [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [1:0]  ex_tag [6] = '{2'd2, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0};
  logic [63:0] ex_res [6] = '{64'h3, 64'h1, 64'h2, 64'h0, 64'h0, 64'h0};
  logic [1:0]  fl_tag [3] = '{2'd0, 2'd1, 2'd2};
`endif

  initial begin
    // Reset with everything pushing
    rst                 = 1'b1;
    bus.req_valid_i     = 1'b1;
    bus.resp_ready_i    = 1'b1;
    bus.flush_i         = 1'b0;
    bus.fpu_in_ready_i  = 1'b1;
    bus.fpu_out_valid_i = 1'b1;
    bus.fpu_result_i    = '0;
    bus.fpu_status_i    = '0;
    bus.fpu_tag_i       = '0;
    bus.fpu_busy_i      = 1'b0;
    set_req(0);
    tick();
    check("rst_req_ready", bus.req_ready_o, 0);
    check("rst_fpu_in_valid", bus.fpu_in_valid_o, 0);
    check("rst_fpu_out_ready", bus.fpu_out_ready_o, 0);
    check("rst_resp_valid", bus.resp_valid_o, 0);
    check("rst_fpu_flush", bus.fpu_flush_o, 0);
    check("rst_busy", bus.busy_o, 0);
    check("rst_tag_err", bus.tag_err_o, 0);

    rst                 = 1'b0;
    bus.fpu_out_valid_i = 1'b0;
    bus.resp_ready_i    = 1'b0;

    // Fill all four tags
    for (int i = 0; i < 4; i++) begin
      set_req(i);
      settle();
      check($sformatf("fill_valid%0d", i), bus.fpu_in_valid_o, 1);
      check($sformatf("fill_tag%0d", i), bus.fpu_tag_o, 64'(i));
      check($sformatf("fill_opa%0d", i), bus.fpu_operands_o[63:0], 64'hA0 + 64'(i));
      check($sformatf("fill_opc%0d", i), bus.fpu_operands_o[191:128], 64'hC0 + 64'(i));
      check($sformatf("fill_cmd%0d", i), bus.fpu_cmd_o, 64'h1230 + 64'(i));
      tick();
    end
    set_req(4);
    settle();
    check("full_req_ready", bus.req_ready_o, 0);
    check("full_fpu_in_valid", bus.fpu_in_valid_o, 0);
    check("full_busy", bus.busy_o, 1);

    // FPU returns tag 0; its retire frees one slot for the next cycle
    bus.req_valid_i     = 1'b0;
    bus.fpu_out_valid_i = 1'b1;
    bus.fpu_tag_i       = 2'd0;
    bus.fpu_result_i    = 64'hA0;
    bus.fpu_status_i    = 5'h01;
`ifdef FPNEW_ISSUE_REORDER_EN
    settle();
    check("ret0_out_ready", bus.fpu_out_ready_o, 1);
    check("ret0_resp_early", bus.resp_valid_o, 0);
    tick();
    bus.fpu_out_valid_i = 1'b0;
`endif
    bus.resp_ready_i = 1'b1;
    bus.req_valid_i  = 1'b1;
    settle();
    check("ret0_resp_valid", bus.resp_valid_o, 1);
    check("ret0_resp_tag", bus.resp_tag_o, 0);
    check("ret0_resp_result", bus.resp_result_o, 64'hA0);
    check("ret0_resp_status", bus.resp_status_o, 64'h01);
    check("ret0_still_full", bus.req_ready_o, 0);
    tick();
    bus.fpu_out_valid_i = 1'b0;
    bus.resp_ready_i    = 1'b0;
    settle();
    check("reissue_ready", bus.req_ready_o, 1);
    check("reissue_tag", bus.fpu_tag_o, 0);
    tick();

    // Asynchronous reset mid-operation drops all state
    rst = 1'b1;
    settle();
    check("midrst_busy", bus.busy_o, 0);
    check("midrst_in_valid", bus.fpu_in_valid_o, 0);
    tick();
    rst             = 1'b0;
    bus.req_valid_i = 1'b0;
    settle();
    check("postrst_busy", bus.busy_o, 0);

    // One op in flight (tag 0), then an unexpected tag 3 result
    bus.req_valid_i = 1'b1;
    set_req(0);
    settle();
    check("sp_issue_tag", bus.fpu_tag_o, 0);
    tick();
    bus.req_valid_i     = 1'b0;
    bus.resp_ready_i    = 1'b1;
    bus.fpu_out_valid_i = 1'b1;
    bus.fpu_tag_i       = 2'd3;
    bus.fpu_result_i    = 64'hBAD;
    settle();
    check("sp_resp_valid", bus.resp_valid_o, 0);
    check("sp_out_ready", bus.fpu_out_ready_o, 1);
    tick();
    bus.fpu_out_valid_i = 1'b0;
    settle();
    check("sp_tag_err_hi", bus.tag_err_o, 1);
    check("sp_resp_after", bus.resp_valid_o, 0);
    tick();
    check("sp_tag_err_lo", bus.tag_err_o, 0);
    check("sp_busy", bus.busy_o, 1);

    // Two more ops: tags 1 and 2
    bus.resp_ready_i = 1'b0;
    bus.req_valid_i  = 1'b1;
    for (int i = 1; i < 3; i++) begin
      set_req(i);
      settle();
      check($sformatf("ro_issue_tag%0d", i), bus.fpu_tag_o, 64'(i));
      tick();
    end
    bus.req_valid_i = 1'b0;

    // FPU returns 2,0,1 out of order
    bus.resp_ready_i = 1'b1;
    bus.fpu_status_i = 5'h00;
    for (int c = 0; c < 6; c++) begin
      bus.fpu_out_valid_i = rt_fv[c][0];
      bus.fpu_tag_i       = rt_ft[c];
      bus.fpu_result_i    = rt_fr[c];
      settle();
      check($sformatf("ro_valid_c%0d", c), bus.resp_valid_o, 64'(ex_v[c]));
      if (ex_v[c]) begin
        check($sformatf("ro_tag_c%0d", c), bus.resp_tag_o, 64'(ex_tag[c]));
        check($sformatf("ro_res_c%0d", c), bus.resp_result_o, ex_res[c]);
      end
      tick();
    end
    bus.fpu_out_valid_i = 1'b0;
    check("ro_idle_busy", bus.busy_o, 0);
    check("ro_no_tag_err", bus.tag_err_o, 0);

    // Three ops in flight, then flush
    bus.resp_ready_i = 1'b0;
    bus.req_valid_i  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_req(i);
      settle();
      check($sformatf("fl_issue_tag%0d", i), bus.fpu_tag_o, 64'(fl_tag[i]));
      tick();
    end
    bus.fpu_busy_i   = 1'b1;
    bus.flush_i      = 1'b1;
    bus.resp_ready_i = 1'b1;
    settle();
    check("fl_req_blocked", bus.req_ready_o, 0);
    check("fl_in_valid_blocked", bus.fpu_in_valid_o, 0);
    check("fl_flush_not_yet", bus.fpu_flush_o, 0);
    tick();
    bus.flush_i     = 1'b0;
    bus.req_valid_i = 1'b0;
    settle();
    check("fl_fpu_flush_hi", bus.fpu_flush_o, 1);
    check("fl_busy", bus.busy_o, 1);
    tick();
    bus.fpu_out_valid_i = 1'b1;
    bus.fpu_tag_i       = 2'd1;
    bus.fpu_result_i    = 64'h77;
    settle();
    check("dr_fpu_flush_lo", bus.fpu_flush_o, 0);
    check("dr_out_ready", bus.fpu_out_ready_o, 1);
    check("dr_resp_valid", bus.resp_valid_o, 0);
    tick();
    bus.fpu_out_valid_i = 1'b0;
    settle();
    check("dr_no_tag_err", bus.tag_err_o, 0);
    check("dr_resp_valid2", bus.resp_valid_o, 0);
    tick();
    bus.fpu_busy_i  = 1'b0;
    bus.req_valid_i = 1'b1;
    settle();
    check("dr_still_busy", bus.busy_o, 1);
    check("dr_req_blocked", bus.req_ready_o, 0);
    tick();
    check("run_busy_clear", bus.busy_o, 0);
    check("run_req_ready", bus.req_ready_o, 1);
    check("run_tag0", bus.fpu_tag_o, 0);
    check("run_no_tag_err", bus.tag_err_o, 0);
    tick();
    bus.req_valid_i = 1'b0;
    settle();
    check("run_busy_after_issue", bus.busy_o, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
